// File: rtl/sissue_pkg.sv
// Shared types for the scalar issue controller: FSM states, held packet,
// register-file constants and the operand hazard check.
package sissue_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_AW    = 5;
  localparam int PKT_IMM_W = 32;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 reg_write_en;
    logic [3:0]           alu_op;
    logic [PKT_IMM_W-1:0] imm;
  } issue_pkt_t;

  // RAW on either source or WAW on the destination; x0 never conflicts.
  function automatic logic reg_hazard(
    input logic                u1,
    input logic [REG_AW-1:0]   rs1,
    input logic                u2,
    input logic [REG_AW-1:0]   rs2,
    input logic                we,
    input logic [REG_AW-1:0]   rd,
    input logic [NUM_REGS-1:0] busy
  );
    return (u1 && rs1 != REG_X0 && busy[rs1]) ||
           (u2 && rs2 != REG_X0 && busy[rs2]) ||
           (we && rd  != REG_X0 && busy[rd]);
  endfunction

endpackage

// File: rtl/sscoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A set and a clear of the same register in one cycle leaves it busy;
// x0 is never marked busy.
module sscoreboard
  import sissue_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_rd,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] busy_nxt
);

  // Next busy vector: clear first so a same-register set overrides it.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[REG_X0] = 1'b0;
  end

  // Busy register, lost immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/sissue_ctrl.sv
// Scoreboarded single-entry issue controller between decode and execute.
// Holds one instruction and issues it once no source/destination register
// has a write in flight. Optional macro SISSUE_WB_BYPASS_EN lets a
// same-cycle writeback release a dependent instruction.
module sissue_ctrl
  import sissue_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [REG_AW-1:0]      in_rs1_i,
  input  logic [REG_AW-1:0]      in_rs2_i,
  input  logic [REG_AW-1:0]      in_rd_i,
  input  logic                   in_uses_rs1_i,
  input  logic                   in_uses_rs2_i,
  input  logic                   in_reg_write_en_i,
  input  logic [3:0]             in_alu_op_i,
  input  logic [DATA_WIDTH-1:0]  in_imm_i,
  output logic                   iss_valid_o,
  input  logic                   iss_ready_i,
  output logic [REG_AW-1:0]      iss_rs1_o,
  output logic [REG_AW-1:0]      iss_rs2_o,
  output logic [REG_AW-1:0]      iss_rd_o,
  output logic                   iss_reg_write_en_o,
  output logic [3:0]             iss_alu_op_o,
  output logic [DATA_WIDTH-1:0]  iss_imm_o,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_rd_i,
  input  logic                   flush_i,
  output logic [NUM_REGS-1:0]    busy_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  issue_state_e          state_q, state_d;
  issue_pkt_t            pkt_q, in_pkt;
  logic [NUM_REGS-1:0]   busy, busy_nxt, busy_eff;
  logic                  hold_valid, hazard, issue_fire, accept, set_en;
  logic [STALL_CNT_W-1:0] stall_q;

  assign in_pkt = '{rs1: in_rs1_i, rs2: in_rs2_i, rd: in_rd_i,
                    uses_rs1: in_uses_rs1_i, uses_rs2: in_uses_rs2_i,
                    reg_write_en: in_reg_write_en_i, alu_op: in_alu_op_i,
                    imm: PKT_IMM_W'(in_imm_i)};

`ifdef SISSUE_WB_BYPASS_EN
  // A retiring write frees its register for issue in the same cycle.
  always_comb begin
    busy_eff = busy;
    if (wb_valid_i) busy_eff[wb_rd_i] = 1'b0;
  end
`else
  // No wb-to-issue combinational path: wait for the registered clear.
  assign busy_eff = busy;
`endif

  assign hold_valid = (state_q != EMPTY);
  assign hazard     = hold_valid &&
                      reg_hazard(pkt_q.uses_rs1, pkt_q.rs1, pkt_q.uses_rs2, pkt_q.rs2,
                                 pkt_q.reg_write_en, pkt_q.rd, busy_eff);
  assign iss_valid_o = hold_valid && !hazard && !flush_i;
  assign issue_fire  = iss_valid_o && iss_ready_i;
  assign in_ready_o  = !flush_i && (!hold_valid || issue_fire);
  assign accept      = in_valid_i && in_ready_o;
  assign set_en      = issue_fire && pkt_q.reg_write_en && (pkt_q.rd != REG_X0);

  sscoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_rd   (pkt_q.rd),
    .clr_en   (wb_valid_i),
    .clr_rd   (wb_rd_i),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

  // Next state: label the held instruction against next cycle's scoreboard.
  always_comb begin
    state_d = state_q;
    if (flush_i)
      state_d = EMPTY;
    else if (accept)
      state_d = reg_hazard(in_pkt.uses_rs1, in_pkt.rs1, in_pkt.uses_rs2, in_pkt.rs2,
                           in_pkt.reg_write_en, in_pkt.rd, busy_nxt) ? STALL : HOLD;
    else if (issue_fire)
      state_d = EMPTY;
    else if (hold_valid)
      state_d = reg_hazard(pkt_q.uses_rs1, pkt_q.rs1, pkt_q.uses_rs2, pkt_q.rs2,
                           pkt_q.reg_write_en, pkt_q.rd, busy_nxt) ? STALL : HOLD;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Payload register: only loads on accept, so it is stable while offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pkt_q <= '0;
    else if (accept) pkt_q <= in_pkt;
  end

  // Saturating count of cycles with a held instruction blocked by a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_q <= '0;
    else if (hazard && stall_q != '1)  stall_q <= stall_q + 1'b1;
  end

  assign iss_rs1_o          = pkt_q.rs1;
  assign iss_rs2_o          = pkt_q.rs2;
  assign iss_rd_o           = pkt_q.rd;
  assign iss_reg_write_en_o = pkt_q.reg_write_en;
  assign iss_alu_op_o       = pkt_q.alu_op;
  assign iss_imm_o          = DATA_WIDTH'(pkt_q.imm);
  assign busy_o             = busy;
  assign stall_cycles_o     = stall_q;

endmodule

// File: tb/tb_sissue_ctrl.sv
// Self-checking bench for sissue_ctrl: directed scenarios plus a randomized
// stream compared against an instruction-level reference model.
module tb_sissue_ctrl;

  localparam int SCW = 4;
`ifdef SISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst_n;
  logic in_valid, in_ready, u1, u2, we, iss_valid, iss_ready, iss_we;
  logic wb_valid, flush;
  logic [4:0] rs1, rs2, rd, iss_rs1, iss_rs2, iss_rd, wb_rd;
  logic [3:0] op, iss_op;
  logic [31:0] imm, iss_imm, busy;
  logic [SCW-1:0] stall;

  int n_tests = 0;
  int n_fail  = 0;

  sissue_ctrl #(.DATA_WIDTH(32), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_i(rs1), .in_rs2_i(rs2), .in_rd_i(rd),
    .in_uses_rs1_i(u1), .in_uses_rs2_i(u2), .in_reg_write_en_i(we),
    .in_alu_op_i(op), .in_imm_i(imm),
    .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
    .iss_rs1_o(iss_rs1), .iss_rs2_o(iss_rs2), .iss_rd_o(iss_rd),
    .iss_reg_write_en_o(iss_we), .iss_alu_op_o(iss_op), .iss_imm_o(iss_imm),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
    .busy_o(busy), .stall_cycles_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    bit u1, u2, we;
    logic [3:0] op;
    logic [31:0] imm;
  } ins_t;

  bit         m_hold;
  ins_t       m_ins;
  bit  [31:0] m_busy;
  int         m_stall;
  bit         m_haz, m_fire, m_acc;

  // Does the held instruction need a register that is still being written?
  function automatic bit m_dep(input ins_t p);
    bit [31:0] pend;
    pend = m_busy;
    if (BYP && wb_valid) pend[wb_rd] = 1'b0;
    return (p.u1 && p.rs1 != 0 && pend[p.rs1]) ||
           (p.u2 && p.rs2 != 0 && pend[p.rs2]) ||
           (p.we && p.rd  != 0 && pend[p.rd]);
  endfunction

  function automatic bit e_iss_valid();
    return m_hold && !m_dep(m_ins) && !flush;
  endfunction

  function automatic bit e_in_ready();
    return !flush && (!m_hold || (e_iss_valid() && iss_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_busy = '0; m_stall = 0;
      m_ins = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, we:0, op:0, imm:0};
    end else begin
      m_haz  = m_hold && m_dep(m_ins);
      m_fire = e_iss_valid() && iss_ready;
      m_acc  = in_valid && e_in_ready();
      if (m_haz && m_stall < (1 << SCW) - 1) m_stall++;
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (m_fire && m_ins.we && m_ins.rd != 0) m_busy[m_ins.rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (flush) m_hold = 0;
      else if (m_acc) begin
        m_hold = 1;
        m_ins = '{rs1:rs1, rs2:rs2, rd:rd, u1:u1, u2:u2, we:we, op:op, imm:imm};
      end else if (m_fire) m_hold = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; we = 0; op = 0; imm = 0;
  endtask

  task automatic put(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input bit ua, input bit ub, input bit w, input logic [31:0] im);
    in_valid = 1; rs1 = a; rs2 = b; rd = d; u1 = ua; u2 = ub; we = w;
    op = 4'(d) ^ 4'h5; imm = im;
  endtask

  task automatic do_reset();
    idle_in();
    iss_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    rst_n = 0; #3;
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_tests++; if (stall !== '0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall); end
    n_tests++;
    if ({iss_rs1, iss_rs2, iss_rd, iss_we, iss_op, iss_imm} !== '0) begin
      n_fail++; $display("FAIL reset_payload got %h want 0", {iss_rs1, iss_rs2, iss_rd, iss_we, iss_op, iss_imm});
    end
  endtask

  task automatic test_independent();
    do_reset();
    put(5'd2, 5'd3, 5'd1, 1, 1, 1, 32'h11);     // add x1,x2,x3
    tick();
    put(5'd5, 5'd6, 5'd4, 1, 1, 1, 32'h44);     // add x4,x5,x6
    #1;
    n_tests++; if (!(iss_valid === 1'b1 && iss_rd === 5'd1 && iss_rs1 === 5'd2 && iss_rs2 === 5'd3))
      begin n_fail++; $display("FAIL indep_first got v=%b rd=%0d want v=1 rd=1", iss_valid, iss_rd); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL indep_b2b_ready got %b want 1", in_ready); end
    tick();
    idle_in(); #1;
    n_tests++; if (!(iss_valid === 1'b1 && iss_rd === 5'd4 && iss_imm === 32'h44))
      begin n_fail++; $display("FAIL indep_second got v=%b rd=%0d want v=1 rd=4", iss_valid, iss_rd); end
    tick(); #1;
    n_tests++; if (busy !== 32'h12) begin n_fail++; $display("FAIL indep_busy got %h want 00000012", busy); end
    n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL indep_drained got %b want 0", iss_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    put(5'd0, 5'd0, 5'd5, 0, 0, 1, 32'h5);      // write x5
    tick();
    put(5'd5, 5'd0, 5'd8, 1, 0, 1, 32'h8);      // uses x5, writes x8
    tick();
    idle_in(); #1;
    n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stalled got %b want 0", iss_valid); end
    n_tests++; if (busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy got %h want 00000020", busy); end
    tick(); #1;
    n_tests++; if (stall !== 4'd1) begin n_fail++; $display("FAIL raw_stall1 got %0d want 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 5'd5; #1;
    n_tests++; if (stall !== 4'd2) begin n_fail++; $display("FAIL raw_stall2 got %0d want 2", stall); end
    n_tests++; if (iss_valid !== BYP) begin n_fail++; $display("FAIL raw_wb_cycle_issue got %b want %b", iss_valid, BYP); end
    tick();
    wb_valid = 0; wb_rd = 0; #1;
    n_tests++; if (iss_valid !== !BYP) begin n_fail++; $display("FAIL raw_after_wb_issue got %b want %b", iss_valid, !BYP); end
    n_tests++; if (stall !== (BYP ? 4'd2 : 4'd3)) begin n_fail++; $display("FAIL raw_stall_final got %0d want %0d", stall, BYP ? 2 : 3); end
    tick(); #1;
    n_tests++; if (busy !== 32'h100 || iss_valid !== 1'b0)
      begin n_fail++; $display("FAIL raw_done got busy=%h v=%b want busy=00000100 v=0", busy, iss_valid); end
  endtask

  task automatic test_waw_x0();
    do_reset();
    put(5'd0, 5'd0, 5'd3, 0, 0, 1, 32'h3);
    tick();
    put(5'd0, 5'd0, 5'd3, 0, 0, 1, 32'h33);     // second write to x3
    tick();
    idle_in(); #1;
    n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL waw_stall got %b want 0", iss_valid); end
    flush = 1; tick(); flush = 0;
    put(5'd0, 5'd0, 5'd0, 1, 0, 1, 32'h0);      // rs1=x0, rd=x0
    tick();
    idle_in(); #1;
    n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall got %b want 1", iss_valid); end
    tick();
    wb_valid = 1; wb_rd = 5'd0; tick(); wb_valid = 0; #1;
    n_tests++; if (busy !== 32'h8) begin n_fail++; $display("FAIL x0_busy got %h want 00000008", busy); end
  endtask

  task automatic test_setclr();
    do_reset();
    put(5'd0, 5'd0, 5'd7, 0, 0, 1, 32'h7);
    tick();
    idle_in(); wb_valid = 1; wb_rd = 5'd7; #1;
    n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL setclr_issue got %b want 1", iss_valid); end
    tick();
    wb_valid = 0; wb_rd = 0; #1;
    n_tests++; if (busy !== 32'h80) begin n_fail++; $display("FAIL setclr_busy got %h want 00000080", busy); end
  endtask

  task automatic test_backpressure_flush();
    do_reset();
    put(5'd0, 5'd0, 5'd9, 0, 0, 1, 32'h9);
    tick();
    put(5'd1, 5'd0, 5'd2, 1, 0, 1, 32'hCAFE_0002);
    tick();
    iss_ready = 0;
    put(5'd3, 5'd4, 5'd6, 1, 1, 1, 32'h6);      // waiting behind the held one
    #1;
    n_tests++; if (in_ready !== 1'b0 || iss_valid !== 1'b1)
      begin n_fail++; $display("FAIL bp_ready got in_ready=%b v=%b want 0/1", in_ready, iss_valid); end
    tick(); tick(); #1;
    n_tests++; if (iss_rd !== 5'd2 || iss_imm !== 32'hCAFE_0002 || iss_valid !== 1'b1)
      begin n_fail++; $display("FAIL bp_stable got rd=%0d imm=%h want rd=2 imm=cafe0002", iss_rd, iss_imm); end
    n_tests++; if (stall !== '0) begin n_fail++; $display("FAIL bp_stall got %0d want 0", stall); end
    flush = 1; #1;
    n_tests++; if (iss_valid !== 1'b0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL flush_outputs got v=%b rdy=%b want 0/0", iss_valid, in_ready); end
    tick();
    flush = 0; idle_in(); iss_ready = 1; #1;
    n_tests++; if (iss_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_empty got v=%b rdy=%b want 0/1", iss_valid, in_ready); end
    n_tests++; if (busy !== 32'h200) begin n_fail++; $display("FAIL flush_busy got %h want 00000200", busy); end
  endtask

  task automatic test_saturate();
    do_reset();
    put(5'd0, 5'd0, 5'd5, 0, 0, 1, 32'h5);
    tick();
    put(5'd5, 5'd0, 5'd0, 1, 0, 0, 32'h0);
    tick();
    idle_in();
    repeat (14) tick();
    #1;
    n_tests++; if (stall !== 4'd14) begin n_fail++; $display("FAIL sat_14 got %0d want 14", stall); end
    repeat (6) tick();
    #1;
    n_tests++; if (stall !== 4'd15) begin n_fail++; $display("FAIL sat_max got %0d want 15", stall); end
  endtask

  task automatic test_async_reset();
    do_reset();
    put(5'd0, 5'd0, 5'd5, 0, 0, 1, 32'h5); tick();
    put(5'd0, 5'd0, 5'd7, 0, 0, 1, 32'h7); tick();
    put(5'd5, 5'd0, 5'd0, 1, 0, 0, 32'h0); tick();
    idle_in(); tick(); #1;
    n_tests++; if (busy !== 32'hA0 || iss_valid !== 1'b0)
      begin n_fail++; $display("FAIL areset_setup got busy=%h v=%b want 000000a0/0", busy, iss_valid); end
    #1 rst_n = 0; #1;
    n_tests++; if (busy !== 32'h0 || iss_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL areset_now got busy=%h v=%b rdy=%b want 0/0/1", busy, iss_valid, in_ready); end
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1); we = $urandom_range(0, 1);
      op = 4'($urandom_range(0, 15)); imm = $urandom;
      iss_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 99) < 35);
      wb_rd     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 99) < 4);
      #1;
      n_tests++; if (iss_valid !== e_iss_valid())
        begin n_fail++; $display("FAIL rnd_iss_valid cyc %0d got %b want %b", c, iss_valid, e_iss_valid()); end
      n_tests++; if (in_ready !== e_in_ready())
        begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, e_in_ready()); end
      n_tests++; if (busy !== m_busy)
        begin n_fail++; $display("FAIL rnd_busy cyc %0d got %h want %h", c, busy, m_busy); end
      n_tests++; if (int'(stall) != m_stall)
        begin n_fail++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", c, stall, m_stall); end
      if (m_hold) begin
        n_tests++;
        if ({iss_rs1, iss_rs2, iss_rd, iss_we, iss_op, iss_imm} !==
            {m_ins.rs1, m_ins.rs2, m_ins.rd, m_ins.we, m_ins.op, m_ins.imm})
          begin n_fail++; $display("FAIL rnd_payload cyc %0d got rd=%0d imm=%h want rd=%0d imm=%h",
                                   c, iss_rd, iss_imm, m_ins.rd, m_ins.imm); end
      end
      tick();
    end
    idle_in(); wb_valid = 0; flush = 0; iss_ready = 1;
  endtask

  initial begin
    rst_n = 0; idle_in(); iss_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    test_reset();
    test_independent();
    test_raw();
    test_waw_x0();
    test_setclr();
    test_backpressure_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sissue_ctrl.md
# sissue_ctrl

Scoreboarded issue controller between the scalar decoder and the execute stage. It holds one decoded instruction, tracks which architectural registers have a write in flight, and issues only when every source and destination register is free. It moves instructions with valid/ready handshakes on both sides and clears pending writes from the writeback port.

## Interface

Parameters:
- `DATA_WIDTH`, 32: immediate width.
- `STALL_CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset. One clock; asynchronous assert; active-low.
- `in_valid_i` input 1: decoded instruction valid.
- `in_ready_o` output 1: controller can accept an instruction this cycle.
- `in_rs1_i`, `in_rs2_i`, `in_rd_i` input 5 each: register addresses.
- `in_uses_rs1_i`, `in_uses_rs2_i`, `in_reg_write_en_i` input 1 each: operand-use flags.
- `in_alu_op_i` input 4: ALU operation.
- `in_imm_i` input DATA_WIDTH: immediate value.
- `iss_valid_o` output 1: held instruction is issuing.
- `iss_ready_i` input 1: execute accepts.
- `iss_rs1_o`, `iss_rs2_o`, `iss_rd_o`, `iss_reg_write_en_o`, `iss_alu_op_o`, `iss_imm_o` output: held payload.
- `wb_valid_i` input 1: writeback retires a register write.
- `wb_rd_i` input 5: retired destination register.
- `flush_i` input 1: kill the held instruction.
- `busy_o` output 32: scoreboard (bit n means write to xn pending). Bit 0 is always 0.
- `stall_cycles_o` output STALL_CNT_W: saturating hazard-stall count.

## Operation

- FSM states:
  - EMPTY: no held instruction.
  - HOLD: instruction held with no hazard.
  - STALL: instruction held and a hazard is present.
- Hazard: any of the following.
  - `uses_rs1 && rs1!=0 && busy_eff[rs1]`
  - `uses_rs2 && rs2!=0 && busy_eff[rs2]`
  - `reg_write_en && rd!=0 && busy_eff[rd]` (write-after-write)
- `iss_valid_o = hold_valid && !hazard`. Issue fires on `iss_valid_o && iss_ready_i`.
- `in_ready_o = !hold_valid || issue_fire`. This allows back-to-back accept and issue in the same cycle.
- On issue with `reg_write_en && rd!=0`, set `busy[rd]` at the next edge.
- On `wb_valid_i`, clear `busy[wb_rd_i]` at the next edge.
  - If the set and the clear hit the same register in the same cycle, the set wins.
  - `wb_rd_i=0` is ignored.
  - A clear of a register that is not busy is a no-op.
- Transitions:
  - EMPTY→HOLD/STALL on accept.
  - HOLD→EMPTY on issue without accept.
  - HOLD→HOLD/STALL on issue with accept.
  - STALL→HOLD when the hazard clears.
- `flush_i`:
  - Drops the held instruction and suppresses acceptance that cycle. `in_ready_o`=0 and the next state is EMPTY.
  - The scoreboard is not cleared, because in-flight writes still retire.
  - Flush has priority over issue: `iss_valid_o`=0 during flush.
- `stall_cycles_o` increments in every cycle spent in STALL and saturates at all-ones.
- Cycles where `iss_ready_i`=0 without a hazard are not counted.

## Timing

- Reset values:
  - State EMPTY.
  - `in_ready_o`=1, `iss_valid_o`=0.
  - All `iss_*` payload outputs 0.
  - `busy_o`=0, `stall_cycles_o`=0.
- Accept-to-issue latency: 1 cycle minimum, because the payload is registered.
- Sustained throughput: 1 instruction per cycle when there are no hazards.
- `iss_valid_o` and `in_ready_o` are combinational from state, `busy`, `wb_*` (see Configuration), `flush_i` and `iss_ready_i`.
- Once `iss_valid_o` is asserted, the payload stays stable until it fires or is flushed.
- Reset mid-operation: the held instruction and all scoreboard bits are lost immediately (asynchronous).

## Configuration

`SISSUE_WB_BYPASS_EN`:
- Defined: `busy_eff = busy & ~(wb_valid_i ? onehot(wb_rd_i) : 0)`. A dependent instruction issues in the same cycle as the writeback of its source.
- Undefined: `busy_eff = busy`. A dependent instruction issues no earlier than one cycle after the writeback, so there is no combinational path from `wb_*` to `iss_valid_o`.

## Structure

- Shared package `sissue_pkg`:
  - `issue_state_e`: EMPTY/HOLD/STALL.
  - `issue_pkt_t` struct: rs1, rs2, rd, flags, alu_op, imm.
  - `REG_X0` constant.
- Sub-module `sscoreboard`: 32-bit busy vector with set/clear ports, set-over-clear priority and x0 masking.
- Hazard logic and FSM remain in `sissue_ctrl`.

## Test plan

- Independent stream: `add x1,x2,x3` then `add x4,x5,x6`, with `iss_ready_i`=1. Required: issues on consecutive cycles; `busy_o` bits 1 and 4 set.
- RAW: issue a write to x5, then an instruction using rs1=x5, with no writeback. Required: STALL, `iss_valid_o`=0, `stall_cycles_o` increments each cycle. After `wb_valid_i`/`wb_rd_i`=5, the dependent instruction issues the same cycle with the macro defined, one cycle later without it.
- WAW and x0: a second write to a busy rd stalls. Writes to rd=0 never set busy, and rs1=0 never stalls.
- Same-cycle set/clear: issue a write to x7 while `wb_rd_i`=7. Required: `busy_o[7]`=1 afterwards.
- Backpressure and flush:
  - With `iss_ready_i`=0 and no hazard: `in_ready_o`=0, payload stable, `stall_cycles_o` unchanged.
  - Then `flush_i`=1: state EMPTY next cycle, `busy_o` unchanged.
- Asynchronous reset while in STALL with busy=0x0000_00A0: `busy_o`=0, `iss_valid_o`=0, `in_ready_o`=1 immediately.
